// File: rtl/iobm_arb_if.sv
// Requester-side port of the I/O bus master arbiter: a held request with its
// transfer attributes, answered by a one-cycle ack carrying bus-error status.
interface iobm_arb_if #(
    parameter int AW = 23
);
    logic          req;
    logic          wr;
    logic          lds;
    logic          uds;
    logic [AW:1]   a;
    logic [15:0]   d;
    logic          ack;
    logic          berr;

    modport master (output req, wr, lds, uds, a, d, input ack, berr);
    modport slave  (input req, wr, lds, uds, a, d, output ack, berr);
endinterface

// File: rtl/iobm_arb.sv
// Two-port round-robin arbiter in front of the PDS I/O bus master; sequences one
// grant through the master's IOACT handshake and acks the owner with error status.
//
// state | meaning
// IDLE  | no grant; pick an owner when any request is up
// REQ   | request outputs driven, waiting for the master to go busy
// ACT   | master busy; collect bus error, run watchdog
// DONE  | master finished; pulse owner's ack
module iobm_arb #(
    parameter int AW     = 23,
    parameter int WD_CYC = 255
) (
    input  logic          c16m,
    input  logic          res,
    iobm_arb_if.slave     r0,
    iobm_arb_if.slave     r1,
    output logic          iordreq,
    output logic          iowrreq,
    output logic          iolds,
    output logic          iouds,
    output logic [AW:1]   ioa,
    output logic [15:0]   iod,
    input  logic          ioact,
    input  logic          ioberr,
    output logic          own,
    output logic          wderr
);
    localparam int WDW = $clog2(WD_CYC + 1);
    localparam logic [WDW-1:0] WD_LIM = WDW'(WD_CYC);

    typedef enum logic [1:0] {IDLE, REQ, ACT, DONE} state_t;

    state_t         state;
    logic [WDW-1:0] wd;
    logic           err;
    logic           pick1;

    // On a tie the port that did not own the bus last time wins.
    assign pick1 = r1.req && (!r0.req || !own);

    always_ff @(posedge c16m) begin
        if (res) begin
            state   <= IDLE;
            iordreq <= 1'b0;
            iowrreq <= 1'b0;
            iolds   <= 1'b0;
            iouds   <= 1'b0;
            ioa     <= '0;
            iod     <= '0;
            own     <= 1'b1;
            wderr   <= 1'b0;
            wd      <= '0;
            err     <= 1'b0;
            r0.ack  <= 1'b0;
            r0.berr <= 1'b0;
            r1.ack  <= 1'b0;
            r1.berr <= 1'b0;
        end else begin
            r0.ack  <= 1'b0;
            r0.berr <= 1'b0;
            r1.ack  <= 1'b0;
            r1.berr <= 1'b0;
            case (state)
                IDLE: begin
                    if (r0.req || r1.req) begin
                        own <= pick1;
                        if (pick1) begin
                            ioa     <= r1.a;
                            iod     <= r1.d;
                            iolds   <= r1.lds;
                            iouds   <= r1.uds;
                            iordreq <= !r1.wr;
                            iowrreq <= r1.wr;
                        end else begin
                            ioa     <= r0.a;
                            iod     <= r0.d;
                            iolds   <= r0.lds;
                            iouds   <= r0.uds;
                            iordreq <= !r0.wr;
                            iowrreq <= r0.wr;
                        end
                        wd    <= '0;
                        state <= REQ;
                    end
                end
                REQ: begin
                    // No timeout here: the master may be held off indefinitely.
                    if (ioact) begin
                        err   <= 1'b0;
                        state <= ACT;
                    end
                end
                ACT: begin
                    if (ioact && ioberr) begin
                        err <= 1'b1;
                    end
                    if (wd != WD_LIM) begin
                        wd <= wd + 1'b1;
                        if (wd + 1'b1 == WD_LIM) begin
                            wderr <= 1'b1;
                        end
                    end
                    if (!ioact) begin
                        iordreq <= 1'b0;
                        iowrreq <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (own) begin
                        r1.ack  <= 1'b1;
                        r1.berr <= err;
                    end else begin
                        r0.ack  <= 1'b1;
                        r0.berr <= err;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
